// File: rtl/i2c_master_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2c_master_sequencer_if
//   Shared drive-select type and the bundle of control/handshake signals
//   between the I2C transaction sequencer, the APB register block, the tx/rx
//   shifters and the output mux.
//
//   Package i2c_seq_pkg
//     DriveSelectType : output mux source (idle / start-stop / tx / rx)
//
//   Interface signals (direction as seen from the sequencer = master modport)
//     in  enable, begin_txn, rw_mode, byte_count[BYTE_CNT_W]   register block
//     in  tx_done, ack_err, rx_done                            shifters
//     out drive_select, start_stop_SDA, start_stop_SCL         output mux
//     out load_addr, load_data, tx_start, rx_start, rx_last    shifters
//     out busy, txn_done, nack_err, timeout_err                register block
// ---------------------------------------------------------------------------
package i2c_seq_pkg;
  typedef enum logic [1:0] {
    DS_IDLE       = 2'd0,
    DS_START_STOP = 2'd1,
    DS_TRANSMIT   = 2'd2,
    DS_RECEIVE    = 2'd3
  } DriveSelectType;
endpackage

interface i2c_master_sequencer_if #(
  parameter int BYTE_CNT_W = 8
);
  import i2c_seq_pkg::*;

  logic                  enable;
  logic                  begin_txn;
  logic                  rw_mode;
  logic [BYTE_CNT_W-1:0] byte_count;
  logic                  tx_done;
  logic                  ack_err;
  logic                  rx_done;

  DriveSelectType        drive_select;
  logic                  start_stop_SDA;
  logic                  start_stop_SCL;
  logic                  load_addr;
  logic                  load_data;
  logic                  tx_start;
  logic                  rx_start;
  logic                  rx_last;
  logic                  busy;
  logic                  txn_done;
  logic                  nack_err;
  logic                  timeout_err;

  modport master (
    input  enable, begin_txn, rw_mode, byte_count, tx_done, ack_err, rx_done,
    output drive_select, start_stop_SDA, start_stop_SCL, load_addr, load_data,
           tx_start, rx_start, rx_last, busy, txn_done, nack_err, timeout_err
  );

  modport slave (
    output enable, begin_txn, rw_mode, byte_count, tx_done, ack_err, rx_done,
    input  drive_select, start_stop_SDA, start_stop_SCL, load_addr, load_data,
           tx_start, rx_start, rx_last, busy, txn_done, nack_err, timeout_err
  );
endinterface

// File: rtl/i2c_master_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_master_sequencer
//   Transaction-level FSM of the I2C master. Runs one transfer
//   START -> address byte -> N data bytes -> STOP. Generates the START/STOP
//   SDA/SCL waveforms itself (each START_*/STOP_* phase lasts CLK_DIV clocks),
//   selects the output mux source and hands byte phases to the tx/rx
//   shifters with one-cycle load/start pulses. All outputs are registered.
//
//   Ports
//     clk    : system clock
//     n_rst  : asynchronous active-low reset (bus released immediately)
//     bus    : i2c_master_sequencer_if.master (see interface file)
//
//   Parameters
//     CLK_DIV     : clocks per start/stop phase (>= 2)
//     BYTE_CNT_W  : width of the data-byte count
//     TIMEOUT_CYC : byte-phase watchdog limit
//
//   Optional feature macro: I2C_SEQ_TIMEOUT_EN
//     defined   : watchdog aborts a byte phase after TIMEOUT_CYC clocks
//                 without the matching done, pulsing timeout_err
//     undefined : no watchdog, timeout_err tied low
// ---------------------------------------------------------------------------
module i2c_master_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int BYTE_CNT_W  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   n_rst,
  i2c_master_sequencer_if.master bus
);

  localparam int PH_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE = BYTE_CNT_W'(1);
  localparam logic [BYTE_CNT_W-1:0] CNT_TWO = BYTE_CNT_W'(2);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_START_A, S_START_B, S_START_C,
    S_ADDR, S_TX_DATA, S_RX_DATA,
    S_STOP_A, S_STOP_B, S_STOP_C
  } state_t;

  state_t                state;
  logic [PH_W-1:0]       phase_cnt;
  logic [BYTE_CNT_W-1:0] remaining;
  logic                  rw_q;
  logic                  phase_end;

  assign phase_end = (phase_cnt == PH_W'(CLK_DIV - 1));

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            in_byte;
  logic            byte_done;
  logic            wd_expire;
  logic            timeout_q;

  assign in_byte   = (state == S_ADDR) || (state == S_TX_DATA) || (state == S_RX_DATA);
  assign byte_done = (((state == S_ADDR) || (state == S_TX_DATA)) && bus.tx_done) ||
                     ((state == S_RX_DATA) && bus.rx_done);
  assign wd_expire = in_byte && !byte_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Byte-to-byte transitions only happen on a done, so clearing on done also
  // covers clearing on state entry; outside byte states the count idles at 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
    end else if (!in_byte || byte_done || wd_expire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= S_IDLE;
      phase_cnt          <= '0;
      remaining          <= '0;
      rw_q               <= 1'b0;
      bus.drive_select   <= DS_IDLE;
      bus.start_stop_SDA <= 1'b1;
      bus.start_stop_SCL <= 1'b1;
      bus.load_addr      <= 1'b0;
      bus.load_data      <= 1'b0;
      bus.tx_start       <= 1'b0;
      bus.rx_start       <= 1'b0;
      bus.rx_last        <= 1'b0;
      bus.busy           <= 1'b0;
      bus.txn_done       <= 1'b0;
      bus.nack_err       <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      timeout_q          <= 1'b0;
`endif
    end else begin
      // One-cycle pulses default low; rx_last is re-evaluated every cycle.
      bus.load_addr <= 1'b0;
      bus.load_data <= 1'b0;
      bus.tx_start  <= 1'b0;
      bus.rx_start  <= 1'b0;
      bus.rx_last   <= 1'b0;
      bus.txn_done  <= 1'b0;
      bus.nack_err  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif

      case (state)
        S_IDLE: begin
          if (bus.begin_txn && bus.enable) begin
            state              <= S_START_A;
            phase_cnt          <= '0;
            rw_q               <= bus.rw_mode;
            remaining          <= bus.byte_count;
            bus.drive_select   <= DS_START_STOP;
            bus.start_stop_SDA <= 1'b1;
            bus.start_stop_SCL <= 1'b1;
            bus.busy           <= 1'b1;
          end
        end

        S_START_A, S_START_B, S_START_C, S_STOP_A, S_STOP_B, S_STOP_C: begin
          if (phase_end) begin
            phase_cnt <= '0;
            case (state)
              S_START_A: begin
                state              <= S_START_B;
                bus.start_stop_SDA <= 1'b0;
                bus.start_stop_SCL <= 1'b1;
              end
              S_START_B: begin
                state              <= S_START_C;
                bus.start_stop_SDA <= 1'b0;
                bus.start_stop_SCL <= 1'b0;
              end
              S_START_C: begin
                state            <= S_ADDR;
                bus.drive_select <= DS_TRANSMIT;
                bus.load_addr    <= 1'b1;
                bus.tx_start     <= 1'b1;
              end
              S_STOP_A: begin
                state              <= S_STOP_B;
                bus.start_stop_SDA <= 1'b0;
                bus.start_stop_SCL <= 1'b1;
              end
              S_STOP_B: begin
                state              <= S_STOP_C;
                bus.start_stop_SDA <= 1'b1;
                bus.start_stop_SCL <= 1'b1;
              end
              default: begin
                state            <= S_IDLE;
                bus.drive_select <= DS_IDLE;
                bus.busy         <= 1'b0;
                bus.txn_done     <= 1'b1;
              end
            endcase
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        S_ADDR: begin
          if (bus.tx_done) begin
            if (bus.ack_err || (remaining == '0) || !bus.enable) begin
              state              <= S_STOP_A;
              phase_cnt          <= '0;
              bus.drive_select   <= DS_START_STOP;
              bus.start_stop_SDA <= 1'b0;
              bus.start_stop_SCL <= 1'b0;
              bus.nack_err       <= bus.ack_err;
            end else if (rw_q) begin
              state            <= S_RX_DATA;
              bus.drive_select <= DS_RECEIVE;
              bus.rx_start     <= 1'b1;
              bus.rx_last      <= (remaining == CNT_ONE);
            end else begin
              state            <= S_TX_DATA;
              bus.drive_select <= DS_TRANSMIT;
              bus.load_data    <= 1'b1;
              bus.tx_start     <= 1'b1;
            end
          end
`ifdef I2C_SEQ_TIMEOUT_EN
          else if (wd_expire) begin
            state              <= S_STOP_A;
            phase_cnt          <= '0;
            bus.drive_select   <= DS_START_STOP;
            bus.start_stop_SDA <= 1'b0;
            bus.start_stop_SCL <= 1'b0;
            timeout_q          <= 1'b1;
          end
`endif
        end

        S_TX_DATA: begin
          if (bus.tx_done) begin
            if (remaining != '0) remaining <= remaining - 1'b1;
            // remaining <= 1 means this was the last byte (count after is 0).
            if (bus.ack_err || (remaining <= CNT_ONE) || !bus.enable) begin
              state              <= S_STOP_A;
              phase_cnt          <= '0;
              bus.drive_select   <= DS_START_STOP;
              bus.start_stop_SDA <= 1'b0;
              bus.start_stop_SCL <= 1'b0;
              bus.nack_err       <= bus.ack_err;
            end else begin
              bus.load_data <= 1'b1;
              bus.tx_start  <= 1'b1;
            end
          end
`ifdef I2C_SEQ_TIMEOUT_EN
          else if (wd_expire) begin
            state              <= S_STOP_A;
            phase_cnt          <= '0;
            bus.drive_select   <= DS_START_STOP;
            bus.start_stop_SDA <= 1'b0;
            bus.start_stop_SCL <= 1'b0;
            timeout_q          <= 1'b1;
          end
`endif
        end

        S_RX_DATA: begin
          if (bus.rx_done) begin
            if (remaining != '0) remaining <= remaining - 1'b1;
            if ((remaining <= CNT_ONE) || !bus.enable) begin
              state              <= S_STOP_A;
              phase_cnt          <= '0;
              bus.drive_select   <= DS_START_STOP;
              bus.start_stop_SDA <= 1'b0;
              bus.start_stop_SCL <= 1'b0;
            end else begin
              bus.rx_start <= 1'b1;
              // Next byte is the last one when the count after this byte is 1.
              bus.rx_last  <= (remaining == CNT_TWO);
            end
          end else begin
            bus.rx_last <= (remaining == CNT_ONE) || !bus.enable;
`ifdef I2C_SEQ_TIMEOUT_EN
            if (wd_expire) begin
              state              <= S_STOP_A;
              phase_cnt          <= '0;
              bus.drive_select   <= DS_START_STOP;
              bus.start_stop_SDA <= 1'b0;
              bus.start_stop_SCL <= 1'b0;
              bus.rx_last        <= 1'b0;
              timeout_q          <= 1'b1;
            end
`endif
          end
        end

        default: begin
          state              <= S_IDLE;
          phase_cnt          <= '0;
          bus.drive_select   <= DS_IDLE;
          bus.start_stop_SDA <= 1'b1;
          bus.start_stop_SCL <= 1'b1;
          bus.busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
